perceptron_trainer: RTL
=======================

# perceptron_trainer

Online training controller for the two-input fixed-point perceptron. It accepts labelled samples on a valid/ready stream and drives them onto the perceptron's `IN1`/`IN2`. It reads back the weighted sum, applies the threshold decision and error-driven learning rule, and writes corrected weights through the perceptron's `weight*_new`/`weight*_ld` ports. Training repeats epochs until an epoch has zero errors or the epoch limit is reached.

## Interface
Parameters:
- `fp_integer_width`, 4, integer bits of the Q format.
- `fp_fract_width`, 12, fraction bits; `fp_width` = sum (16).
- `learning_rate`, 16'h0400, signed Q4.12 step size (0.25).
- `max_epochs`, 16, epoch limit; legal range 1..255.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`, in, 1: clock; all state updates on rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: begin a training run; ignored unless idle or done.
- `sample_valid`, in, 1: sample offered.
- `sample_ready`, out, 1: trainer can accept a sample.
- `sample_x1`, `sample_x2`, in, 16: signed Q4.12 features.
- `sample_target`, in, 1: desired class.
- `sample_last`, in, 1: final sample of the epoch.
- `in1`, `in2`, out, 16: registered features to perceptron `IN1`/`IN2`.
- `result`, in, 16: perceptron weighted sum, signed Q4.12.
- `weight1`, `weight2`, in, 16: current perceptron weights.
- `weight1_new`, `weight2_new`, out, 16: updated weights.
- `weight1_ld`, `weight2_ld`, out, 1: one-cycle load strobes.
- `busy`, out, 1: run in progress.
- `done`, out, 1: run finished; held until `start` or `rst`.
- `converged`, out, 1: last completed epoch had zero errors.
- `epoch_count`, out, 8: epochs completed in this run.
- `epoch_errors`, out, 16: misclassifications in the current epoch, saturating at 16'hFFFF.

## Operation
- States: IDLE, WAIT, EVAL, UPDATE, EPOCH_END, DONE.
- IDLE/DONE + `start` → WAIT.
  - Clears `done`, `converged`, `epoch_count` and `epoch_errors`.
  - Does not touch the weights; training resumes from the perceptron's current values.
- WAIT:
  - `sample_ready`=1.
  - On `sample_valid && sample_ready`: latch x1/x2 into `in1`/`in2`, latch target and last, go to EVAL.
- EVAL:
  - Predicted class = 1 when `result[15]`==0 (result ≥ 0), else 0.
  - err = target − predicted, in {−1, 0, +1}.
  - For each i: d_i = (learning_rate × x_i), full 32-bit signed product, arithmetic shift right by `fp_fract_width`, saturated to 16-bit signed.
  - w_new_i = weight_i + err·d_i, saturated to [16'h8000, 16'h7FFF].
  - Register w_new_i into `weight*_new`.
  - If err≠0, increment `epoch_errors` (saturating).
  - Go to UPDATE.
- UPDATE:
  - `weight1_ld`=`weight2_ld`=1 only if err≠0; otherwise 0 and `weight*_new` is don't-care.
  - Next state is EPOCH_END if last, else WAIT.
- EPOCH_END:
  - Increment `epoch_count`.
  - If `epoch_errors`==0: `converged`=1 → DONE.
  - Else if the new `epoch_count` equals `max_epochs` → DONE with `converged`=0.
  - Else clear `epoch_errors` → WAIT.
- DONE: `done`=1, `busy`=0; `epoch_errors` holds the final epoch's count.
- `busy`=1 in WAIT, EVAL, UPDATE and EPOCH_END.
- `start` outside IDLE/DONE is ignored.

## Timing
- Reset values: state IDLE; `sample_ready`, `busy`, `done`, `converged`, `weight*_ld` all 0; `in1`, `in2`, `weight*_new`, `epoch_count`, `epoch_errors` all 0.
- Sample accepted at edge T (WAIT):
  - `in1`/`in2` valid from T+1.
  - The perceptron is combinational, so `result` is sampled in EVAL during cycle T+1.
  - `weight*_ld` is asserted in cycle T+2 and the perceptron captures at the end of T+2.
  - Next sample is accepted no earlier than the edge ending T+3.
  - Throughput: one sample per 3 cycles, plus 1 cycle per epoch end.
- `sample_ready` is low in EVAL, UPDATE, EPOCH_END, IDLE and DONE. A sample held valid during those states is taken on the first WAIT cycle.
- `sample_last` is sampled only at acceptance.
- `rst` has priority over all other inputs. When asserted in any state, the next cycle is IDLE with reset values, and `ld` is deasserted even mid-UPDATE. The perceptron's own weights are not reset by this block.
- `start` and `rst` in the same cycle: reset wins.

## Test plan
- Reset: assert `rst` 2 cycles, with any inputs → all outputs at reset values and `sample_ready`=0.
- Single update:
  - Setup: weights 0, `start`, sample (16'h1000, 16'h1000, target 0, last).
  - Response: `result`=0 → predicted 1, err −1.
  - At T+2: `weight1_new`=`weight2_new`=16'hFC00 with both `ld`=1.
  - Afterwards: `epoch_errors`=1, and a second epoch begins.
- No-error sample: weights 0, sample (16'h1000, 0, target 1) → no `ld` pulse and `epoch_errors` unchanged.
- Saturation: `weight1`=16'h7F00, x1=16'h7FFF, target 1 with `result` negative → d=16'h1FFF and `weight1_new`=16'h7FFF (clamped).
- Convergence:
  - Samples per epoch: (16'h1000, 0, target 1) and (16'hF000, 0, target 0, last), from weights 0.
  - Epoch 1: one error, w1 → 16'h0400.
  - Epoch 2: zero errors.
  - Final: `done`=1, `converged`=1, `epoch_count`=2.
- Limit, backpressure and reset:
  - Limit: contradictory samples (16'h1000, 0, target 1) then (16'h1000, 0, target 0, last), with `max_epochs`=3 → `done`=1, `converged`=0, `epoch_count`=3.
  - Reset mid-run: `rst` asserted in UPDATE → no `ld` next cycle, IDLE.
  - Backpressure: `sample_valid` held high throughout → exactly one acceptance per 3 cycles.

Source files
------------

// File: rtl/perceptron_trainer.sv
`default_nettype none
// ============================================================================
// Module   : perceptron_trainer
// Brief    : Online error-driven trainer for a two-input Q4.12 perceptron.
// Revision : 1.0 - initial release
// ============================================================================
module perceptron_trainer #(
  parameter int fp_integer_width = 4,
  parameter int fp_fract_width   = 12,
  parameter logic [fp_integer_width+fp_fract_width-1:0] learning_rate = 16'h0400,
  parameter int max_epochs       = 16
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       start,
  input  logic                                       sample_valid,
  output logic                                       sample_ready,
  input  logic [fp_integer_width+fp_fract_width-1:0] sample_x1,
  input  logic [fp_integer_width+fp_fract_width-1:0] sample_x2,
  input  logic                                       sample_target,
  input  logic                                       sample_last,
  output logic [fp_integer_width+fp_fract_width-1:0] in1,
  output logic [fp_integer_width+fp_fract_width-1:0] in2,
  input  logic [fp_integer_width+fp_fract_width-1:0] result,
  input  logic [fp_integer_width+fp_fract_width-1:0] weight1,
  input  logic [fp_integer_width+fp_fract_width-1:0] weight2,
  output logic [fp_integer_width+fp_fract_width-1:0] weight1_new,
  output logic [fp_integer_width+fp_fract_width-1:0] weight2_new,
  output logic                                       weight1_ld,
  output logic                                       weight2_ld,
  output logic                                       busy,
  output logic                                       done,
  output logic                                       converged,
  output logic [7:0]                                 epoch_count,
  output logic [15:0]                                epoch_errors
);

  localparam int c_fw = fp_integer_width + fp_fract_width;
  localparam int c_ew = 2 * c_fw;

  localparam logic [2:0] c_st_idle      = 3'd0;
  localparam logic [2:0] c_st_wait      = 3'd1;
  localparam logic [2:0] c_st_eval      = 3'd2;
  localparam logic [2:0] c_st_update    = 3'd3;
  localparam logic [2:0] c_st_epoch_end = 3'd4;
  localparam logic [2:0] c_st_done      = 3'd5;

  localparam logic signed [c_ew-1:0] c_sat_hi = {{(c_fw+1){1'b0}}, {(c_fw-1){1'b1}}};
  localparam logic signed [c_ew-1:0] c_sat_lo = {{(c_fw+1){1'b1}}, {(c_fw-1){1'b0}}};
  localparam logic [7:0]             c_max_epochs = 8'(max_epochs);

  // Clamp a double-width signed value into the single-width Q range.
  function automatic logic [c_fw-1:0] f_sat(input logic signed [c_ew-1:0] v);
    if (v > c_sat_hi)
      f_sat = c_sat_hi[c_fw-1:0];
    else if (v < c_sat_lo)
      f_sat = c_sat_lo[c_fw-1:0];
    else
      f_sat = v[c_fw-1:0];
  endfunction

  logic [2:0]             r_state;
  logic [c_fw-1:0]        r_in1;
  logic [c_fw-1:0]        r_in2;
  logic [c_fw-1:0]        r_w1_new;
  logic [c_fw-1:0]        r_w2_new;
  logic                   r_target;
  logic                   r_last;
  logic                   r_ld;
  logic                   r_done;
  logic                   r_converged;
  logic [7:0]             r_epoch_count;
  logic [15:0]            r_epoch_errors;

  logic                   w_pred;
  logic                   w_err_pos;
  logic                   w_err_neg;
  logic                   w_err_nz;
  logic signed [c_ew-1:0] w_lr_ext;
  logic signed [c_ew-1:0] w_x1_ext;
  logic signed [c_ew-1:0] w_x2_ext;
  logic signed [c_ew-1:0] w_prod1;
  logic signed [c_ew-1:0] w_prod2;
  logic [c_fw-1:0]        w_d1;
  logic [c_fw-1:0]        w_d2;
  logic signed [c_ew-1:0] w_d1_ext;
  logic signed [c_ew-1:0] w_d2_ext;
  logic signed [c_ew-1:0] w_wt1_ext;
  logic signed [c_ew-1:0] w_wt2_ext;
  logic signed [c_ew-1:0] w_sum1;
  logic signed [c_ew-1:0] w_sum2;
  logic [c_fw-1:0]        w_new1;
  logic [c_fw-1:0]        w_new2;
  logic [7:0]             w_epoch_next;
  logic                   w_unused_result;

  // Only the sign of the weighted sum drives the decision.
  assign w_pred          = ~result[c_fw-1];
  assign w_unused_result = ^result[c_fw-2:0];
  assign w_err_pos       = r_target & ~w_pred;
  assign w_err_neg       = ~r_target & w_pred;
  assign w_err_nz        = w_err_pos | w_err_neg;

  assign w_lr_ext  = {{c_fw{learning_rate[c_fw-1]}}, learning_rate};
  assign w_x1_ext  = {{c_fw{r_in1[c_fw-1]}}, r_in1};
  assign w_x2_ext  = {{c_fw{r_in2[c_fw-1]}}, r_in2};
  assign w_prod1   = w_lr_ext * w_x1_ext;
  assign w_prod2   = w_lr_ext * w_x2_ext;
  assign w_d1      = f_sat(w_prod1 >>> fp_fract_width);
  assign w_d2      = f_sat(w_prod2 >>> fp_fract_width);
  assign w_d1_ext  = {{c_fw{w_d1[c_fw-1]}}, w_d1};
  assign w_d2_ext  = {{c_fw{w_d2[c_fw-1]}}, w_d2};
  assign w_wt1_ext = {{c_fw{weight1[c_fw-1]}}, weight1};
  assign w_wt2_ext = {{c_fw{weight2[c_fw-1]}}, weight2};
  assign w_sum1    = w_err_pos ? (w_wt1_ext + w_d1_ext) : (w_wt1_ext - w_d1_ext);
  assign w_sum2    = w_err_pos ? (w_wt2_ext + w_d2_ext) : (w_wt2_ext - w_d2_ext);
  assign w_new1    = f_sat(w_sum1);
  assign w_new2    = f_sat(w_sum2);

  assign w_epoch_next = r_epoch_count + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= c_st_idle;
      r_in1          <= '0;
      r_in2          <= '0;
      r_w1_new       <= '0;
      r_w2_new       <= '0;
      r_target       <= 1'b0;
      r_last         <= 1'b0;
      r_ld           <= 1'b0;
      r_done         <= 1'b0;
      r_converged    <= 1'b0;
      r_epoch_count  <= 8'd0;
      r_epoch_errors <= 16'd0;
    end else begin
      r_ld <= 1'b0;
      case (r_state)
        c_st_idle, c_st_done: begin
          if (start) begin
            r_state        <= c_st_wait;
            r_done         <= 1'b0;
            r_converged    <= 1'b0;
            r_epoch_count  <= 8'd0;
            r_epoch_errors <= 16'd0;
          end
        end
        c_st_wait: begin
          if (sample_valid) begin
            r_in1    <= sample_x1;
            r_in2    <= sample_x2;
            r_target <= sample_target;
            r_last   <= sample_last;
            r_state  <= c_st_eval;
          end
        end
        c_st_eval: begin
          r_w1_new <= w_new1;
          r_w2_new <= w_new2;
          r_ld     <= w_err_nz;
          if (w_err_nz && (r_epoch_errors != 16'hFFFF))
            r_epoch_errors <= r_epoch_errors + 16'd1;
          r_state  <= c_st_update;
        end
        c_st_update: begin
          r_state <= r_last ? c_st_epoch_end : c_st_wait;
        end
        c_st_epoch_end: begin
          r_epoch_count <= w_epoch_next;
          if (r_epoch_errors == 16'd0) begin
            r_converged <= 1'b1;
            r_done      <= 1'b1;
            r_state     <= c_st_done;
          end else if (w_epoch_next == c_max_epochs) begin
            r_done  <= 1'b1;
            r_state <= c_st_done;
          end else begin
            r_epoch_errors <= 16'd0;
            r_state        <= c_st_wait;
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  assign sample_ready = (r_state == c_st_wait);
  assign busy         = (r_state == c_st_wait) || (r_state == c_st_eval) ||
                        (r_state == c_st_update) || (r_state == c_st_epoch_end);
  assign done         = r_done;
  assign converged    = r_converged;
  assign in1          = r_in1;
  assign in2          = r_in2;
  assign weight1_new  = r_w1_new;
  assign weight2_new  = r_w2_new;
  assign weight1_ld   = r_ld;
  assign weight2_ld   = r_ld;
  assign epoch_count  = r_epoch_count;
  assign epoch_errors = r_epoch_errors;

endmodule
`default_nettype wire
